spi_master_fifo: RTL

Parametrised SPI master: the successor to the fixed 8-bit, single-buffered, fixed-divider SPI controller in the SoC. It adds programmable data width, NUM_SS slave selects, runtime CPOL/CPHA/LSB-first, a runtime clock divider, and TX/RX FIFOs. It sits on the CPU register bus as a memory-mapped slave and drives the external SPI pins of the audio peripherals.

---
 rtl/spi_master_fifo.sv | 274 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/spi_master_fifo.sv
// SPI master with register-bus access, TX/RX FIFOs, runtime mode/divider
// and NUM_SS slave selects. Configuration is latched per word on the way
// into LOAD, so bus writes made mid-frame only affect the next word.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | no frame; SCLK follows CPOL, SS_n released unless SSO forces it
// LOAD  | one cycle; word popped from TX, config latched, MOSI = first bit
// LEAD  | SS_n asserted, SCLK at CPOL for one half-period
// XFER  | 2*DATA_W half-periods, SCLK toggles at the end of each
// TRAIL | SCLK at CPOL for one half-period, received word pushed to RX

module spi_master_fifo #(
    parameter int DATA_W     = 8,
    parameter int NUM_SS     = 1,
    parameter int FIFO_DEPTH = 8,
    parameter int DIV_W      = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              chipselect,
    input  logic [2:0]        address,
    input  logic              read_n,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    output logic              irq,
    output logic              SCLK,
    output logic              MOSI,
    input  logic              MISO,
    output logic [NUM_SS-1:0] SS_n
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;
    localparam int EW = $clog2(2 * DATA_W + 1);
    localparam logic [EW-1:0] LAST_EDGE_IDX = EW'(2 * DATA_W - 1);
    localparam logic [PW-1:0] DEPTH_CNT = PW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_LEAD,
        S_XFER,
        S_TRAIL
    } state_t;

    state_t state, next_state;

    logic              wr_en, rd_en;
    logic [8:0]        ctrl;
    logic [DIV_W-1:0]  clkdiv;
    logic [NUM_SS-1:0] ssel;
    logic              toe, roe;
    logic              unused_bits;

    logic [DATA_W-1:0] tx_mem [FIFO_DEPTH];
    logic [DATA_W-1:0] rx_mem [FIFO_DEPTH];
    logic [PW-1:0]     tx_wp, tx_rp, tx_cnt, rx_wp, rx_rp, rx_cnt;
    logic              tx_full, tx_empty, rx_full, rx_empty;
    logic              tx_push_req, tx_push, tx_pop;
    logic              rx_push_req, rx_push, rx_pop;
    logic [DATA_W-1:0] tx_rd_data;

    logic              cfg_cpol, cfg_cpha, cfg_lsb;
    logic [DIV_W-1:0]  cfg_div;
    logic [NUM_SS-1:0] cfg_ssel, ss_use;
    logic [DATA_W-1:0] tx_sh, rx_sh, tx_next, rx_in;
    logic [DIV_W-1:0]  div_cnt;
    logic [EW-1:0]     edge_cnt;
    logic              div_zero, sample_now, shift_now, next_bit;
    logic              rrdy, trdy, tmt, busy;
    logic [31:0]       status;

    assign unused_bits = ^writedata;

    assign wr_en = chipselect & ~write_n;
    assign rd_en = chipselect & ~read_n;

    assign tx_cnt   = tx_wp - tx_rp;
    assign rx_cnt   = rx_wp - rx_rp;
    assign tx_full  = (tx_cnt == DEPTH_CNT);
    assign rx_full  = (rx_cnt == DEPTH_CNT);
    assign tx_empty = (tx_cnt == '0);
    assign rx_empty = (rx_cnt == '0);

    // A push against a full FIFO still lands if the same cycle frees a slot.
    assign tx_push_req = wr_en && (address == 3'd1);
    assign tx_push     = tx_push_req && (!tx_full || tx_pop);
    assign rx_pop      = rd_en && (address == 3'd0) && !rx_empty;
    assign rx_push     = rx_push_req && (!rx_full || rx_pop);
    assign tx_rd_data  = tx_mem[tx_rp[AW-1:0]];

    assign rrdy = !rx_empty;
    assign trdy = !tx_full;
    assign tmt  = tx_empty && (state == S_IDLE);
    assign busy = (state != S_IDLE);
    assign status = {8'd0, 8'(rx_cnt), 8'(tx_cnt), 2'd0, busy, roe, toe, tmt, trdy, rrdy};

    assign div_zero   = (div_cnt == '0);
    assign sample_now = cfg_cpha ? edge_cnt[0] : ~edge_cnt[0];
    assign shift_now  = cfg_cpha ? (edge_cnt[0] == 1'b0 && edge_cnt != '0)
                                 : (edge_cnt[0] == 1'b1 && edge_cnt != LAST_EDGE_IDX);
    assign tx_next    = cfg_lsb ? (tx_sh >> 1) : (tx_sh << 1);
    assign next_bit   = cfg_lsb ? tx_next[0] : tx_next[DATA_W-1];
    assign rx_in      = cfg_lsb ? {MISO, rx_sh[DATA_W-1:1]} : {rx_sh[DATA_W-2:0], MISO};
    assign ss_use     = tx_pop ? ssel : cfg_ssel;

    // Configuration registers written from the bus.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctrl   <= '0;
            clkdiv <= '0;
            ssel   <= NUM_SS'(1);
        end else if (wr_en) begin
            case (address)
                3'd3:    ctrl   <= writedata[8:0];
                3'd4:    clkdiv <= writedata[DIV_W-1:0];
                3'd5:    ssel   <= writedata[NUM_SS-1:0];
                default: ;
            endcase
        end
    end

    // Sticky overflow flags; a new event beats a simultaneous clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            toe <= 1'b0;
            roe <= 1'b0;
        end else begin
            if (tx_push_req && tx_full && !tx_pop) toe <= 1'b1;
            else if (wr_en && address == 3'd2)     toe <= 1'b0;
            if (rx_push_req && rx_full && !rx_pop) roe <= 1'b1;
            else if (wr_en && address == 3'd2)     roe <= 1'b0;
        end
    end

    // FIFO pointers carry an extra wrap bit so full and empty differ.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_wp <= '0;
            tx_rp <= '0;
            rx_wp <= '0;
            rx_rp <= '0;
        end else begin
            if (tx_push) tx_wp <= tx_wp + PW'(1);
            if (tx_pop)  tx_rp <= tx_rp + PW'(1);
            if (rx_push) rx_wp <= rx_wp + PW'(1);
            if (rx_pop)  rx_rp <= rx_rp + PW'(1);
        end
    end

    // FIFO storage needs no reset; the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wp[AW-1:0]] <= writedata[DATA_W-1:0];
        if (rx_push) rx_mem[rx_wp[AW-1:0]] <= rx_sh;
    end

    // Registered read port; reading an empty RX returns zero.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= '0;
        end else if (rd_en) begin
            case (address)
                3'd0:    readdata <= rx_empty ? 32'd0 : 32'(rx_mem[rx_rp[AW-1:0]]);
                3'd2:    readdata <= status;
                3'd3:    readdata <= 32'(ctrl);
                3'd4:    readdata <= 32'(clkdiv);
                3'd5:    readdata <= 32'(ssel);
                default: readdata <= '0;
            endcase
        end
    end

    // Interrupt is the registered OR of enabled status conditions.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) irq <= 1'b0;
        else          irq <= |(ctrl[8:4] & {roe, toe, tmt, trdy, rrdy});
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= next_state;
    end

    // FSM next state; the TX pop happens on the transition into LOAD.
    always_comb begin
        next_state  = state;
        tx_pop      = 1'b0;
        rx_push_req = 1'b0;
        case (state)
            S_IDLE: begin
                if (!tx_empty) begin
                    next_state = S_LOAD;
                    tx_pop     = 1'b1;
                end
            end
            S_LOAD: next_state = S_LEAD;
            S_LEAD: if (div_zero) next_state = S_XFER;
            S_XFER: if (div_zero && edge_cnt == LAST_EDGE_IDX) next_state = S_TRAIL;
            S_TRAIL: begin
                if (div_zero) begin
                    rx_push_req = 1'b1;
                    if (!tx_empty) begin
                        next_state = S_LOAD;
                        tx_pop     = 1'b1;
                    end else begin
                        next_state = S_IDLE;
                    end
                end
            end
            default: next_state = S_IDLE;
        endcase
    end

    // Serial datapath: per-word config latch, half-period timer, shifters.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cfg_cpol <= 1'b0;
            cfg_cpha <= 1'b0;
            cfg_lsb  <= 1'b0;
            cfg_div  <= '0;
            cfg_ssel <= '0;
            tx_sh    <= '0;
            rx_sh    <= '0;
            div_cnt  <= '0;
            edge_cnt <= '0;
            SCLK     <= 1'b0;
            MOSI     <= 1'b0;
        end else if (tx_pop) begin
            cfg_cpol <= ctrl[0];
            cfg_cpha <= ctrl[1];
            cfg_lsb  <= ctrl[2];
            cfg_div  <= clkdiv;
            cfg_ssel <= ssel;
            tx_sh    <= tx_rd_data;
            MOSI     <= ctrl[2] ? tx_rd_data[0] : tx_rd_data[DATA_W-1];
            SCLK     <= ctrl[0];
            edge_cnt <= '0;
        end else begin
            case (state)
                S_IDLE: SCLK <= ctrl[0];
                S_LOAD: div_cnt <= cfg_div;
                S_LEAD, S_TRAIL: div_cnt <= div_zero ? cfg_div : div_cnt - DIV_W'(1);
                S_XFER: begin
                    div_cnt <= div_zero ? cfg_div : div_cnt - DIV_W'(1);
                    if (div_zero) begin
                        SCLK     <= ~SCLK;
                        edge_cnt <= edge_cnt + EW'(1);
                        if (sample_now) rx_sh <= rx_in;
                        if (shift_now) begin
                            tx_sh <= tx_next;
                            MOSI  <= next_bit;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Slave selects stay asserted across back-to-back words and when SSO forces them.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            SS_n <= '1;
        end else if (next_state == S_IDLE || (next_state == S_LOAD && state == S_IDLE)) begin
            SS_n <= ctrl[3] ? ~ssel : '1;
        end else begin
            SS_n <= ~ss_use;
        end
    end

endmodule
